key_ctrl: RTL and testbench
===========================

KEY_CTRL -- requirements
Module: key_ctrl

Interface
REQ-001 Parameter: NUM_KEYS, 4, number of push-button inputs (1..32).
REQ-002 Parameter: DEBOUNCE_CYCLES, 500000, clock cycles an input must hold a new level before acceptance (>=2).
REQ-003 Port: clk  input  1  system clock; sole clock of the block.
REQ-004 Port: reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: address  input  2  Avalon-MM word address.
REQ-006 Port: chipselect  input  1  slave select; qualifies write_n.
REQ-007 Port: write_n  input  1  active-low write strobe.
REQ-008 Port: writedata  input  32  write data.
REQ-009 Port: readdata  output  32  registered read data.
REQ-010 Port: Key_in  input  NUM_KEYS  raw push buttons, asynchronous, active-low (0 = pressed).
REQ-011 Port: irq  output  1  level interrupt, active-high.

Function
REQ-012 Each Key_in bit SHALL pass a 2-flop synchronizer before any other use.
REQ-013 Per key: if synchronized level equals stable level, counter SHALL clear to 0; otherwise it SHALL increment each cycle.
REQ-014 When counter reaches DEBOUNCE_CYCLES-1 with levels still differing, stable level SHALL take the synchronized level next cycle and counter SHALL clear.
REQ-015 Glitch shorter than DEBOUNCE_CYCLES SHALL never change stable level.
REQ-016 Stable 1->0 transition (press) SHALL set the key's edge-capture bit; 0->1 (release) SHALL not.
REQ-017 Register map, writes when chipselect=1 and write_n=0: 0 = stable levels (RO); 1 = interrupt mask bits [NUM_KEYS-1:0] (RW); 2 = edge capture (read; write-1-to-clear per bit); 3 = synchronized raw levels (RO).
REQ-018 Writes to addresses 0 and 3 SHALL have no effect.
REQ-019 readdata SHALL update every clock with selected register, zero-extended; read latency 1 cycle.
REQ-020 Unused readdata bits above NUM_KEYS-1 SHALL read 0.
REQ-021 Same-cycle set and write-1-clear of one edge bit: set SHALL win.
REQ-022 irq SHALL be registered: irq <= |(edge_capture & mask); 1-cycle lag after edge or mask change.
REQ-023 Counter width SHALL be clog2(DEBOUNCE_CYCLES); counter SHALL never wrap.

Reset
REQ-024 On reset_n=0, immediately: synchronizer flops and stable levels = all 1 (released), counters = 0, mask = 0, edge capture = 0, readdata = 0, irq = 0.
REQ-025 Reset mid-debounce SHALL discard partial count; no edge SHALL be generated by reset release.

Structure
REQ-026 Shared package SHALL hold register address constants (ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=2, ADDR_RAW=3).
REQ-027 Per-key synchronizer+counter+stable flop SHALL be sub-module key_debounce, generated NUM_KEYS times; outputs stable level and 1-cycle press pulse.
REQ-028 Register file, edge capture and irq SHALL live in key_ctrl.

Verification (DEBOUNCE_CYCLES=8, NUM_KEYS=4)
REQ-029 Reset release with Key_in=4'hF -> readdata=0 after reset, addr 0 reads 32'h0000000F, irq=0.
REQ-030 Key_in[0]=0 held 20 cycles -> addr 0 reads 32'h0000000E; addr 2 reads 32'h00000001; irq stays 0 (mask=0).
REQ-031 Key_in[1] pulsed low 5 cycles -> addr 0 stays 32'h0000000F, addr 2 stays 0.
REQ-032 Write mask=4'h4, press key 2 -> irq=1 one cycle after edge bit sets; write 32'h4 to addr 2 -> edge=0, irq=0 next cycle.
REQ-033 Write-1-clear to addr 2 in the same cycle a new key-2 press edge occurs -> bit 2 remains 1, irq remains 1.
REQ-034 reset_n low while key 3 counter is at 5 -> all registers 0 immediately; after release with key 3 still low, edge bit 3 sets only after full 8-cycle debounce plus synchronizer delay.

Source files
------------

// File: rtl/key_ctrl_pkg.sv
// Shared constants and bus payload types for the push-button controller.
package key_ctrl_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_RAW  = 2'd3;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } avl_req_t;

endpackage

// File: rtl/key_debounce.sv
// One push button: 2-flop synchronizer, hold counter and accepted (stable) level.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_sync,
    output logic key_stable,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta;
    logic [CNT_W-1:0] cnt;

    // Counter runs only while the synchronized level disagrees; it clears on
    // acceptance, so it never passes CNT_MAX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta       <= 1'b1;
            key_sync   <= 1'b1;
            key_stable <= 1'b1;
            cnt        <= '0;
            press      <= 1'b0;
        end else begin
            meta     <= key_raw;
            key_sync <= meta;
            press    <= 1'b0;
            if (key_sync == key_stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                key_stable <= key_sync;
                cnt        <= '0;
                press      <= ~key_sync;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_ctrl.sv
// Avalon-MM push-button controller: debounced levels, press edge capture and masked irq.
module key_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_KEYS-1:0] Key_in,
    output logic                irq
);

    logic [NUM_KEYS-1:0] raw_sync;
    logic [NUM_KEYS-1:0] stable;
    logic [NUM_KEYS-1:0] press;
    logic [NUM_KEYS-1:0] mask;
    logic [NUM_KEYS-1:0] edge_cap;
    logic [NUM_KEYS-1:0] edge_clr_c;
    logic [NUM_KEYS-1:0] edge_nxt_c;
    logic [DATA_W-1:0]   rdata_nxt_c;
    avl_req_t            req_c;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk       (clk),
            .reset_n   (reset_n),
            .key_raw   (Key_in[i]),
            .key_sync  (raw_sync[i]),
            .key_stable(stable[i]),
            .press     (press[i])
        );
    end

    if (NUM_KEYS < DATA_W) begin : g_wdata_hi
        logic unused_wdata_hi;
        assign unused_wdata_hi = ^writedata[DATA_W-1:NUM_KEYS];
    end

    assign req_c.wr    = chipselect & ~write_n;
    assign req_c.addr  = address;
    assign req_c.wdata = writedata;

    // A press in the same cycle as a write-1-clear keeps its bit set.
    always_comb begin
        edge_clr_c  = '0;
        rdata_nxt_c = '0;
        if (req_c.wr && req_c.addr == ADDR_EDGE) begin
            edge_clr_c = req_c.wdata[NUM_KEYS-1:0];
        end
        edge_nxt_c = (edge_cap & ~edge_clr_c) | press;
        case (req_c.addr)
            ADDR_DATA: rdata_nxt_c = DATA_W'(stable);
            ADDR_MASK: rdata_nxt_c = DATA_W'(mask);
            ADDR_EDGE: rdata_nxt_c = DATA_W'(edge_cap);
            ADDR_RAW:  rdata_nxt_c = DATA_W'(raw_sync);
            default:   rdata_nxt_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask     <= '0;
            edge_cap <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (req_c.wr && req_c.addr == ADDR_MASK) begin
                mask <= req_c.wdata[NUM_KEYS-1:0];
            end
            edge_cap <= edge_nxt_c;
            readdata <= rdata_nxt_c;
            irq      <= |(edge_cap & mask);
        end
    end

endmodule

// File: tb/tb_key_ctrl.sv
// Directed self-checking bench for key_ctrl with a short debounce window.
module tb_key_ctrl;
    import key_ctrl_pkg::*;

    localparam int unsigned NUM_KEYS = 4;
    localparam int unsigned DEB      = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [3:0]  Key_in = 4'hF;
    logic        irq;

    int pass_cnt = 0;
    int total_cnt = 0;

    key_ctrl #(
        .NUM_KEYS       (NUM_KEYS),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .Key_in    (Key_in),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
        address = ADDR_DATA;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = ADDR_DATA;
        writedata  = '0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if (readdata !== 32'h0) $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected %b", irq, 1'b0);
        else pass_cnt++;
        tick(3);
        reset_n = 1'b1;
        rd(ADDR_DATA, d);
        total_cnt++;
        if (d !== 32'h0000000F) $display("FAIL reset_data: got %h expected %h", d, 32'h0000000F);
        else pass_cnt++;
        rd(ADDR_MASK, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL reset_mask: got %h expected %h", d, 32'h0);
        else pass_cnt++;
        rd(ADDR_EDGE, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL reset_edge: got %h expected %h", d, 32'h0);
        else pass_cnt++;
        rd(ADDR_RAW, d);
        total_cnt++;
        if (d !== 32'h0000000F) $display("FAIL reset_raw: got %h expected %h", d, 32'h0000000F);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL reset_irq_after: got %b expected %b", irq, 1'b0);
        else pass_cnt++;
    endtask

    task automatic test_press;
        logic [31:0] d;
        Key_in = 4'hE;
        tick(20);
        rd(ADDR_DATA, d);
        total_cnt++;
        if (d !== 32'h0000000E) $display("FAIL press_data: got %h expected %h", d, 32'h0000000E);
        else pass_cnt++;
        rd(ADDR_EDGE, d);
        total_cnt++;
        if (d !== 32'h00000001) $display("FAIL press_edge: got %h expected %h", d, 32'h00000001);
        else pass_cnt++;
        rd(ADDR_RAW, d);
        total_cnt++;
        if (d !== 32'h0000000E) $display("FAIL press_raw: got %h expected %h", d, 32'h0000000E);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL press_irq_masked: got %b expected %b", irq, 1'b0);
        else pass_cnt++;
        wr(ADDR_EDGE, 32'h1);
        rd(ADDR_EDGE, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL press_w1c: got %h expected %h", d, 32'h0);
        else pass_cnt++;
        Key_in = 4'hF;
        tick(20);
        rd(ADDR_EDGE, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL release_no_edge: got %h expected %h", d, 32'h0);
        else pass_cnt++;
        rd(ADDR_DATA, d);
        total_cnt++;
        if (d !== 32'h0000000F) $display("FAIL release_data: got %h expected %h", d, 32'h0000000F);
        else pass_cnt++;
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        Key_in = 4'hD;
        tick(5);
        Key_in = 4'hF;
        tick(20);
        rd(ADDR_DATA, d);
        total_cnt++;
        if (d !== 32'h0000000F) $display("FAIL glitch5_data: got %h expected %h", d, 32'h0000000F);
        else pass_cnt++;
        rd(ADDR_EDGE, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL glitch5_edge: got %h expected %h", d, 32'h0);
        else pass_cnt++;
        Key_in = 4'hD;
        tick(7);
        Key_in = 4'hF;
        tick(20);
        rd(ADDR_EDGE, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL glitch7_edge: got %h expected %h", d, 32'h0);
        else pass_cnt++;
        Key_in = 4'hD;
        tick(8);
        Key_in = 4'hF;
        tick(20);
        rd(ADDR_EDGE, d);
        total_cnt++;
        if (d !== 32'h00000002) $display("FAIL hold8_edge: got %h expected %h", d, 32'h00000002);
        else pass_cnt++;
        rd(ADDR_DATA, d);
        total_cnt++;
        if (d !== 32'h0000000F) $display("FAIL hold8_data: got %h expected %h", d, 32'h0000000F);
        else pass_cnt++;
        wr(ADDR_EDGE, 32'h2);
    endtask

    task automatic test_irq;
        logic [31:0] d;
        wr(ADDR_MASK, 32'hFFFF_FFF4);
        rd(ADDR_MASK, d);
        total_cnt++;
        if (d !== 32'h00000004) $display("FAIL mask_read: got %h expected %h", d, 32'h00000004);
        else pass_cnt++;
        Key_in = 4'hB;
        tick(11);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_lag: got %b expected %b", irq, 1'b0);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_set: got %b expected %b", irq, 1'b1);
        else pass_cnt++;
        rd(ADDR_EDGE, d);
        total_cnt++;
        if (d !== 32'h00000004) $display("FAIL irq_edge: got %h expected %h", d, 32'h00000004);
        else pass_cnt++;
        wr(ADDR_EDGE, 32'h4);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL irq_clear_lag: got %b expected %b", irq, 1'b1);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL irq_cleared: got %b expected %b", irq, 1'b0);
        else pass_cnt++;
        rd(ADDR_EDGE, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL irq_edge_cleared: got %h expected %h", d, 32'h0);
        else pass_cnt++;
        wr(ADDR_DATA, 32'h0);
        rd(ADDR_DATA, d);
        total_cnt++;
        if (d !== 32'h0000000B) $display("FAIL ro_data_write: got %h expected %h", d, 32'h0000000B);
        else pass_cnt++;
        wr(ADDR_RAW, 32'h0);
        rd(ADDR_RAW, d);
        total_cnt++;
        if (d !== 32'h0000000B) $display("FAIL ro_raw_write: got %h expected %h", d, 32'h0000000B);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        Key_in = 4'hF;
        tick(20);
        Key_in = 4'hB;
        tick(20);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL b2b_first_irq: got %b expected %b", irq, 1'b1);
        else pass_cnt++;
        Key_in = 4'hF;
        tick(20);
        Key_in = 4'hB;
        tick(10);
        wr(ADDR_EDGE, 32'h4);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL b2b_irq_at_write: got %b expected %b", irq, 1'b1);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (irq !== 1'b1) $display("FAIL b2b_irq_after: got %b expected %b", irq, 1'b1);
        else pass_cnt++;
        rd(ADDR_EDGE, d);
        total_cnt++;
        if (d !== 32'h00000004) $display("FAIL b2b_set_wins: got %h expected %h", d, 32'h00000004);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        Key_in = 4'h7;
        tick(7);
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (readdata !== 32'h0) $display("FAIL mid_reset_readdata: got %h expected %h", readdata, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL mid_reset_irq: got %b expected %b", irq, 1'b0);
        else pass_cnt++;
        tick(2);
        address = ADDR_EDGE;
        reset_n = 1'b1;
        tick(11);
        total_cnt++;
        if (readdata !== 32'h0) $display("FAIL mid_edge_early: got %h expected %h", readdata, 32'h0);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (readdata !== 32'h00000008) $display("FAIL mid_edge_set: got %h expected %h", readdata, 32'h00000008);
        else pass_cnt++;
        rd(ADDR_DATA, d);
        total_cnt++;
        if (d !== 32'h00000007) $display("FAIL mid_data: got %h expected %h", d, 32'h00000007);
        else pass_cnt++;
        rd(ADDR_MASK, d);
        total_cnt++;
        if (d !== 32'h0) $display("FAIL mid_mask: got %h expected %h", d, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (irq !== 1'b0) $display("FAIL mid_irq_masked: got %b expected %b", irq, 1'b0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_irq();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
